// File: rtl/frontend_redirect_recv_if.sv
// Redirect/recovery bundle between the backend redirect controller and the frontend
// recovery owner: redirect + branch-resolve in, flush/squash/restore/update/restart out.
interface frontend_redirect_recv_if #(
    parameter int FSQ_WIDTH  = 5,
    parameter int VADDR_SIZE = 39
);
    logic                  redirect_en;
    logic [FSQ_WIDTH-1:0]  redirect_fsq_idx;
    logic [VADDR_SIZE-1:0] redirect_pc;
    logic                  csr_en;
    logic                  br_en;
    logic                  br_taken;
    logic [1:0]            br_type;
    logic [1:0]            ras_type;
    logic                  fetch_flush;
    logic                  fsq_squash_en;
    logic [FSQ_WIDTH-1:0]  fsq_squash_idx;
    logic                  bpu_restore_en;
    logic [FSQ_WIDTH-1:0]  bpu_restore_idx;
    logic                  bpu_update_en;
    logic                  bpu_update_taken;
    logic [1:0]            bpu_update_br_type;
    logic [1:0]            bpu_update_ras_type;
    logic                  restart_valid;
    logic [VADDR_SIZE-1:0] restart_pc;
    logic                  restart_ready;
    logic                  busy;

    modport master (
        output redirect_en, redirect_fsq_idx, redirect_pc, csr_en, br_en, br_taken,
               br_type, ras_type, restart_ready,
        input  fetch_flush, fsq_squash_en, fsq_squash_idx, bpu_restore_en, bpu_restore_idx,
               bpu_update_en, bpu_update_taken, bpu_update_br_type, bpu_update_ras_type,
               restart_valid, restart_pc, busy
    );

    modport slave (
        input  redirect_en, redirect_fsq_idx, redirect_pc, csr_en, br_en, br_taken,
               br_type, ras_type, restart_ready,
        output fetch_flush, fsq_squash_en, fsq_squash_idx, bpu_restore_en, bpu_restore_idx,
               bpu_update_en, bpu_update_taken, bpu_update_br_type, bpu_update_ras_type,
               restart_valid, restart_pc, busy
    );
endinterface

// File: rtl/frontend_redirect_recv.sv
// Frontend redirect receiver: FLUSH -> RESTORE (RESTORE_CYCLES) -> RESTART sequence owner.
// Optional REDIRECT_PERF_EN adds saturating redirect/recovery-cycle performance counters.
module frontend_redirect_recv #(
    parameter int FSQ_WIDTH      = 5,
    parameter int VADDR_SIZE     = 39,
    parameter int RESTORE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    frontend_redirect_recv_if.slave rif
`ifdef REDIRECT_PERF_EN
    ,
    output logic [31:0] perf_redirect_cnt,
    output logic [31:0] perf_recover_cyc
`endif
);
    localparam int CNT_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTORE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, RESTORE, RESTART} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FSQ_WIDTH-1:0]  idx_q, idx_d;
    logic [VADDR_SIZE-1:0] pc_q, pc_d;
    logic                  csr_q, csr_d;
    logic                  br_en_q, br_en_d;
    logic                  taken_q, taken_d;
    logic [1:0]            br_type_q, br_type_d;
    logic [1:0]            ras_type_q, ras_type_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            pc_q       <= '0;
            csr_q      <= 1'b0;
            br_en_q    <= 1'b0;
            taken_q    <= 1'b0;
            br_type_q  <= '0;
            ras_type_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pc_q       <= pc_d;
            csr_q      <= csr_d;
            br_en_q    <= br_en_d;
            taken_q    <= taken_d;
            br_type_q  <= br_type_d;
            ras_type_q <= ras_type_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pc_d       = pc_q;
        csr_d      = csr_q;
        br_en_d    = br_en_q;
        taken_d    = taken_q;
        br_type_d  = br_type_q;
        ras_type_d = ras_type_q;
        case (state_q)
            IDLE:    ;
            FLUSH: begin
                state_d = RESTORE;
                cnt_d   = CNT_LOAD;
            end
            RESTORE: begin
                if (cnt_q == '0) state_d = RESTART;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RESTART: begin
                if (rif.restart_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new redirect always wins: the backend has already chosen the oldest one,
        // so any in-flight recovery (including a pending restart) is abandoned.
        if (rif.redirect_en) begin
            state_d    = FLUSH;
            cnt_d      = CNT_LOAD;
            idx_d      = rif.redirect_fsq_idx;
            pc_d       = rif.redirect_pc;
            csr_d      = rif.csr_en;
            br_en_d    = rif.br_en;
            taken_d    = rif.br_taken;
            br_type_d  = rif.br_type;
            ras_type_d = rif.ras_type;
        end
    end

    // Outputs decode only flopped state/latches; payloads are zero while their enable is low.
    always_comb begin
        rif.fetch_flush         = 1'b0;
        rif.fsq_squash_en       = 1'b0;
        rif.fsq_squash_idx      = '0;
        rif.bpu_restore_en      = 1'b0;
        rif.bpu_restore_idx     = '0;
        rif.bpu_update_en       = 1'b0;
        rif.bpu_update_taken    = 1'b0;
        rif.bpu_update_br_type  = '0;
        rif.bpu_update_ras_type = '0;
        rif.restart_valid       = 1'b0;
        rif.restart_pc          = '0;
        rif.busy                = (state_q != IDLE);
        case (state_q)
            FLUSH: begin
                rif.fetch_flush    = 1'b1;
                rif.fsq_squash_en  = 1'b1;
                rif.fsq_squash_idx = idx_q;
                if (br_en_q && !csr_q) begin
                    rif.bpu_update_en       = 1'b1;
                    rif.bpu_update_taken    = taken_q;
                    rif.bpu_update_br_type  = br_type_q;
                    rif.bpu_update_ras_type = ras_type_q;
                end
            end
            RESTORE: begin
                rif.bpu_restore_en  = 1'b1;
                rif.bpu_restore_idx = idx_q;
            end
            RESTART: begin
                rif.restart_valid = 1'b1;
                rif.restart_pc    = pc_q;
            end
            default: ;
        endcase
    end

`ifdef REDIRECT_PERF_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] recover_cyc_q, recover_cyc_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        recover_cyc_d  = recover_cyc_q;
        if (rif.redirect_en && (redirect_cnt_q != '1)) redirect_cnt_d = redirect_cnt_q + 32'd1;
        if ((state_q != IDLE) && (recover_cyc_q != '1)) recover_cyc_d = recover_cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt_q <= '0;
            recover_cyc_q  <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            recover_cyc_q  <= recover_cyc_d;
        end
    end

    assign perf_redirect_cnt = redirect_cnt_q;
    assign perf_recover_cyc  = recover_cyc_q;
`endif
endmodule

// File: tb/tb_frontend_redirect_recv.sv
// Scoreboard bench for frontend_redirect_recv: expected per-cycle output snapshots are
// queued when a redirect is driven and popped/compared on each falling clock edge.
module tb_frontend_redirect_recv;
    localparam int FW = 5;
    localparam int VW = 39;
    localparam int RC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    frontend_redirect_recv_if #(.FSQ_WIDTH(FW), .VADDR_SIZE(VW)) rif ();
`ifdef REDIRECT_PERF_EN
    logic [31:0] perf_redirect_cnt;
    logic [31:0] perf_recover_cyc;
`endif

    frontend_redirect_recv #(.FSQ_WIDTH(FW), .VADDR_SIZE(VW), .RESTORE_CYCLES(RC)) dut (
        .clk (clk),
        .rst (rst),
        .rif (rif)
`ifdef REDIRECT_PERF_EN
        ,
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_recover_cyc  (perf_recover_cyc)
`endif
    );

    typedef struct packed {
        logic          ff;
        logic          sq;
        logic [FW-1:0] sqi;
        logic          re;
        logic [FW-1:0] rei;
        logic          ue;
        logic          ut;
        logic [1:0]    ubt;
        logic [1:0]    urt;
        logic          rv;
        logic [VW-1:0] rpc;
        logic          busy;
    } snap_t;

    snap_t sbq[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    hs_cnt   = 0;

    always @(posedge clk) if (rif.restart_valid === 1'b1 && rif.restart_ready === 1'b1) hs_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic snap_t sample();
        snap_t s;
        s.ff = rif.fetch_flush;       s.sq = rif.fsq_squash_en;     s.sqi = rif.fsq_squash_idx;
        s.re = rif.bpu_restore_en;    s.rei = rif.bpu_restore_idx;
        s.ue = rif.bpu_update_en;     s.ut = rif.bpu_update_taken;
        s.ubt = rif.bpu_update_br_type; s.urt = rif.bpu_update_ras_type;
        s.rv = rif.restart_valid;     s.rpc = rif.restart_pc;       s.busy = rif.busy;
        return s;
    endfunction

    function automatic snap_t f_idle();
        snap_t s = '0;
        return s;
    endfunction

    function automatic snap_t f_flush(input logic [FW-1:0] i, input logic ue, input logic ut,
                                      input logic [1:0] bt, input logic [1:0] rt);
        snap_t s = '0;
        s.ff = 1'b1; s.sq = 1'b1; s.sqi = i; s.busy = 1'b1;
        if (ue) begin s.ue = 1'b1; s.ut = ut; s.ubt = bt; s.urt = rt; end
        return s;
    endfunction

    function automatic snap_t f_restore(input logic [FW-1:0] i);
        snap_t s = '0;
        s.re = 1'b1; s.rei = i; s.busy = 1'b1;
        return s;
    endfunction

    function automatic snap_t f_restart(input logic [VW-1:0] pc);
        snap_t s = '0;
        s.rv = 1'b1; s.rpc = pc; s.busy = 1'b1;
        return s;
    endfunction

    task automatic drive_redirect(input logic [FW-1:0] idx, input logic [VW-1:0] pc,
                                  input logic csr, input logic br, input logic tk,
                                  input logic [1:0] bt, input logic [1:0] rt);
        rif.redirect_en = 1'b1; rif.redirect_fsq_idx = idx; rif.redirect_pc = pc;
        rif.csr_en = csr; rif.br_en = br; rif.br_taken = tk; rif.br_type = bt; rif.ras_type = rt;
    endtask

    task automatic clear_redirect();
        rif.redirect_en = 1'b0; rif.redirect_fsq_idx = '0; rif.redirect_pc = '0;
        rif.csr_en = 1'b0; rif.br_en = 1'b0; rif.br_taken = 1'b0; rif.br_type = '0; rif.ras_type = '0;
    endtask

    task automatic test_reset();
        snap_t exp, obs;
        sbq.push_back(f_idle());
        sbq.push_back(f_idle());
        exp = sbq.pop_front(); obs = sample(); n_assert++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, exp); end
        rst = 1'b1;
        @(negedge clk);
        exp = sbq.pop_front(); obs = sample(); n_assert++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs, exp); end
    endtask

    task automatic test_branch();
        snap_t exp, obs;
        int hs0;
`ifdef REDIRECT_PERF_EN
        logic [31:0] rc0, cy0;
        rc0 = perf_redirect_cnt; cy0 = perf_recover_cyc;
`endif
        hs0 = hs_cnt;
        sbq.push_back(f_flush(5'd3, 1'b1, 1'b1, 2'b01, 2'b10));
        repeat (RC) sbq.push_back(f_restore(5'd3));
        sbq.push_back(f_restart(39'h80001000));
        sbq.push_back(f_idle());
        drive_redirect(5'd3, 39'h80001000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b10);
        @(negedge clk);
        clear_redirect();
        while (sbq.size() > 0) begin
            exp = sbq.pop_front(); obs = sample(); n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL branch: got %h want %h", obs, exp); end
            @(negedge clk);
        end
        n_assert++;
        if (hs_cnt - hs0 !== 1) begin n_fail++; $display("FAIL branch_hs: got %0d want 1", hs_cnt - hs0); end
`ifdef REDIRECT_PERF_EN
        n_assert++;
        if (perf_redirect_cnt - rc0 !== 32'd1) begin
            n_fail++; $display("FAIL perf_redirect: got %0d want 1", perf_redirect_cnt - rc0);
        end
        n_assert++;
        if (perf_recover_cyc - cy0 !== 32'(RC + 2)) begin
            n_fail++; $display("FAIL perf_cycles: got %0d want %0d", perf_recover_cyc - cy0, RC + 2);
        end
`endif
    endtask

    task automatic test_csr();
        snap_t exp, obs;
        sbq.push_back(f_flush(5'd12, 1'b0, 1'b0, 2'b00, 2'b00));
        repeat (RC) sbq.push_back(f_restore(5'd12));
        sbq.push_back(f_restart(39'h80000000));
        sbq.push_back(f_idle());
        drive_redirect(5'd12, 39'h80000000, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01);
        @(negedge clk);
        clear_redirect();
        while (sbq.size() > 0) begin
            exp = sbq.pop_front(); obs = sample(); n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL csr: got %h want %h", obs, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_br_without_redirect();
        snap_t exp, obs;
        sbq.push_back(f_idle());
        sbq.push_back(f_idle());
        rif.br_en = 1'b1; rif.br_taken = 1'b1; rif.redirect_fsq_idx = 5'd9; rif.redirect_pc = 39'h1234;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp = sbq.pop_front(); obs = sample(); n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL br_only: got %h want %h", obs, exp); end
            @(negedge clk);
        end
        clear_redirect();
    endtask

    task automatic test_backpressure();
        snap_t exp, obs;
        int hs0;
        hs0 = hs_cnt;
        sbq.push_back(f_flush(5'd4, 1'b1, 1'b0, 2'b10, 2'b00));
        repeat (RC) sbq.push_back(f_restore(5'd4));
        repeat (6) sbq.push_back(f_restart(39'h4000_0040));
        sbq.push_back(f_idle());
        rif.restart_ready = 1'b0;
        drive_redirect(5'd4, 39'h4000_0040, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00);
        @(negedge clk);
        clear_redirect();
        for (int i = 0; sbq.size() > 0; i++) begin
            exp = sbq.pop_front(); obs = sample(); n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL backpressure c%0d: got %h want %h", i, obs, exp); end
            if (i == RC + 6) rif.restart_ready = 1'b1;
            @(negedge clk);
        end
        n_assert++;
        if (hs_cnt - hs0 !== 1) begin n_fail++; $display("FAIL backpressure_hs: got %0d want 1", hs_cnt - hs0); end
    endtask

    task automatic test_back_to_back();
        snap_t exp, obs;
        sbq.push_back(f_flush(5'd1, 1'b1, 1'b1, 2'b01, 2'b00));
        sbq.push_back(f_restore(5'd1));
        sbq.push_back(f_flush(5'd7, 1'b0, 1'b0, 2'b00, 2'b00));
        repeat (RC) sbq.push_back(f_restore(5'd7));
        sbq.push_back(f_restart(39'h200));
        sbq.push_back(f_idle());
        drive_redirect(5'd1, 39'h1000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00);
        @(negedge clk);
        clear_redirect();
        for (int i = 0; sbq.size() > 0; i++) begin
            exp = sbq.pop_front(); obs = sample(); n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL second_redirect c%0d: got %h want %h", i, obs, exp); end
            if (i == 1) drive_redirect(5'd7, 39'h200, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
            if (i == 2) clear_redirect();
            @(negedge clk);
        end
    endtask

    task automatic test_coincident();
        snap_t exp, obs;
        int hs0;
        hs0 = hs_cnt;
        sbq.push_back(f_flush(5'd2, 1'b1, 1'b0, 2'b11, 2'b11));
        repeat (RC) sbq.push_back(f_restore(5'd2));
        sbq.push_back(f_restart(39'h3000));
        sbq.push_back(f_flush(5'd9, 1'b0, 1'b0, 2'b00, 2'b00));
        repeat (RC) sbq.push_back(f_restore(5'd9));
        sbq.push_back(f_restart(39'h4000));
        sbq.push_back(f_idle());
        drive_redirect(5'd2, 39'h3000, 1'b0, 1'b1, 1'b0, 2'b11, 2'b11);
        @(negedge clk);
        clear_redirect();
        for (int i = 0; sbq.size() > 0; i++) begin
            exp = sbq.pop_front(); obs = sample(); n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL coincident c%0d: got %h want %h", i, obs, exp); end
            if (i == RC + 1) drive_redirect(5'd9, 39'h4000, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01);
            if (i == RC + 2) clear_redirect();
            @(negedge clk);
        end
        n_assert++;
        if (hs_cnt - hs0 !== 2) begin n_fail++; $display("FAIL coincident_hs: got %0d want 2", hs_cnt - hs0); end
    endtask

    task automatic test_async_reset();
        snap_t exp, obs;
        sbq.push_back(f_flush(5'd5, 1'b1, 1'b1, 2'b00, 2'b10));
        repeat (RC) sbq.push_back(f_restore(5'd5));
        sbq.push_back(f_restart(39'h5555));
        drive_redirect(5'd5, 39'h5555, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10);
        @(negedge clk);
        clear_redirect();
        rif.restart_ready = 1'b0;
        while (sbq.size() > 0) begin
            exp = sbq.pop_front(); obs = sample(); n_assert++;
            if (obs !== exp) begin n_fail++; $display("FAIL pre_reset: got %h want %h", obs, exp); end
            if (sbq.size() > 0) @(negedge clk);
        end
        sbq.push_back(f_idle());
        sbq.push_back(f_idle());
        #2 rst = 1'b0;
        #1;
        exp = sbq.pop_front(); obs = sample(); n_assert++;
        if (obs !== exp) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs, exp); end
`ifdef REDIRECT_PERF_EN
        n_assert++;
        if (perf_redirect_cnt !== 32'd0 || perf_recover_cyc !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_redirect_cnt, perf_recover_cyc);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        rif.restart_ready = 1'b1;
        @(negedge clk);
        exp = sbq.pop_front(); obs = sample(); n_assert++;
        if (obs !== exp) begin n_fail++; $display("FAIL post_reset: got %h want %h", obs, exp); end
    endtask

    initial begin
        clear_redirect();
        rif.restart_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_branch();
        test_csr();
        test_br_without_redirect();
        test_backpressure();
        test_back_to_back();
        test_coincident();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
